// File: rtl/if_fetch_pkg.sv
// if_fetch_pkg: constants and types shared across the instruction-fetch slice.
//   AddrLen / InstLen  : address and instruction widths
//   ZERO_WORD          : all-zero word used for reset values
//   True / False       : single-bit boolean constants
//   ICacheIndexLen     : default log2 of the instruction-cache line count
//   if_state_t         : fetch state machine encoding (IF_IDLE, IF_FETCH)
package if_fetch_pkg;

   localparam int          AddrLen        = 32;
   localparam int          InstLen        = 32;
   localparam logic [31:0] ZERO_WORD      = 32'h0000_0000;
   localparam logic        True           = 1'b1;
   localparam logic        False          = 1'b0;
   localparam int          ICacheIndexLen = 5;

   typedef enum logic {
      IF_IDLE  = 1'b0,
      IF_FETCH = 1'b1
   } if_state_t;

endpackage

// File: rtl/if_fetch_icache_dm.sv
// icache_dm: direct-mapped, one-word-per-line instruction cache.
//   clk, rst      : clock, synchronous active-high reset (clears valid bits only)
//   rd_index/tag  : lookup address split; hit/rd_data are combinational
//   we            : write strobe; writes data, tag and sets valid at the edge
//   wr_index/tag  : line being filled
//   wr_data       : word written into the line
module icache_dm
   import if_fetch_pkg::*;
#(
   parameter int ICACHE_ENTRIES = 32,
   parameter int INDEX_W        = ICacheIndexLen,
   parameter int TAG_W          = AddrLen - INDEX_W - 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [INDEX_W-1:0] rd_index,
   input  logic [TAG_W-1:0]   rd_tag,
   output logic               hit,
   output logic [InstLen-1:0] rd_data,
   input  logic               we,
   input  logic [INDEX_W-1:0] wr_index,
   input  logic [TAG_W-1:0]   wr_tag,
   input  logic [InstLen-1:0] wr_data
);

   logic [InstLen-1:0]        data_mem [ICACHE_ENTRIES];
   logic [TAG_W-1:0]          tag_mem  [ICACHE_ENTRIES];
   logic [ICACHE_ENTRIES-1:0] valid;

   always_ff @(posedge clk) begin
      if (rst)
         valid <= '0;
      else if (we)
         valid[wr_index] <= True;
   end

   // Data and tag arrays carry no reset; the valid bits alone qualify them.
   always_ff @(posedge clk) begin
      if (we) begin
         data_mem[wr_index] <= wr_data;
         tag_mem[wr_index]  <= wr_tag;
      end
   end

   assign hit     = valid[rd_index] && (tag_mem[rd_index] == rd_tag);
   assign rd_data = data_mem[rd_index];

endmodule

// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch unit. Looks each PC up in a direct-mapped cache;
// hits return in one cycle, misses assemble the word from four little-endian
// byte reads on the memory byte port and fill the line.
//   clk, rst                     : clock, synchronous active-high reset
//   rdy                          : global ready, all state freezes when low
//   pc_i, pc_valid_i             : PC stream from the PC generator
//   fetch_stall_o                : combinational hold request to the PC generator
//   jump_i                       : flush; squashes any fetch in progress
//   mem_req_o, mem_addr_o        : byte-read request and byte address
//   mem_byte_i, mem_byte_valid_i : returned byte and its strobe
//   id_stall_i                   : decode backpressure
//   inst_valid_o, inst_o, inst_pc_o : instruction output register to IF/ID
module if_fetch
   import if_fetch_pkg::*;
#(
   parameter int ICACHE_ENTRIES = 32,
   parameter int INDEX_W        = ICacheIndexLen
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rdy,
   input  logic [AddrLen-1:0] pc_i,
   input  logic               pc_valid_i,
   output logic               fetch_stall_o,
   input  logic               jump_i,
   output logic               mem_req_o,
   output logic [AddrLen-1:0] mem_addr_o,
   input  logic [7:0]         mem_byte_i,
   input  logic               mem_byte_valid_i,
   input  logic               id_stall_i,
   output logic               inst_valid_o,
   output logic [InstLen-1:0] inst_o,
   output logic [AddrLen-1:0] inst_pc_o
);

   localparam int TAG_W = AddrLen - INDEX_W - 2;

   if_state_t          state, state_next;
   logic [1:0]         cnt;
   logic [AddrLen-1:0] fpc;
   logic [23:0]        asm_buf;
   logic               hit;
   logic [InstLen-1:0] hit_data;
   logic               out_held;
   logic               load_hit;
   logic               start_miss;
   logic               take_byte;
   logic               last_byte;
   logic               cache_we;
   logic               unused_pc_lsb;

   assign unused_pc_lsb = ^pc_i[1:0];

   icache_dm #(
      .ICACHE_ENTRIES (ICACHE_ENTRIES),
      .INDEX_W        (INDEX_W),
      .TAG_W          (TAG_W)
   ) u_icache (
      .clk      (clk),
      .rst      (rst),
      .rd_index (pc_i[INDEX_W+1:2]),
      .rd_tag   (pc_i[AddrLen-1:INDEX_W+2]),
      .hit      (hit),
      .rd_data  (hit_data),
      .we       (cache_we),
      .wr_index (fpc[INDEX_W+1:2]),
      .wr_tag   (fpc[AddrLen-1:INDEX_W+2]),
      .wr_data  ({mem_byte_i, asm_buf})
   );

   assign out_held   = inst_valid_o && id_stall_i;
   assign load_hit   = (state == IF_IDLE) && pc_valid_i && hit && !out_held;
   assign start_miss = (state == IF_IDLE) && pc_valid_i && !hit;
   // The final byte is only taken once the output register is free, so a
   // completed fill never overwrites an instruction decode has not consumed.
   assign take_byte  = (state == IF_FETCH) && mem_byte_valid_i &&
                       ((cnt != 2'd3) || !out_held);
   assign last_byte  = take_byte && (cnt == 2'd3);
   assign cache_we   = !rst && rdy && !jump_i && last_byte;

   assign mem_req_o     = (state == IF_FETCH);
   assign mem_addr_o    = fpc + {30'd0, cnt};
   assign fetch_stall_o = (state == IF_FETCH) || (pc_valid_i && !hit) || out_held;

   always_comb begin
      state_next = state;
      if (jump_i)
         state_next = IF_IDLE;
      else begin
         case (state)
            IF_IDLE:  if (start_miss) state_next = IF_FETCH;
            IF_FETCH: if (last_byte)  state_next = IF_IDLE;
            default:  state_next = IF_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         state <= IF_IDLE;
      else if (rdy)
         state <= state_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt          <= 2'd0;
         fpc          <= ZERO_WORD;
         inst_valid_o <= False;
         inst_o       <= ZERO_WORD;
         inst_pc_o    <= ZERO_WORD;
      end else if (rdy) begin
         if (jump_i) begin
            cnt          <= 2'd0;
            inst_valid_o <= False;
         end else begin
            if (inst_valid_o && !id_stall_i)
               inst_valid_o <= False;
            if (load_hit) begin
               inst_valid_o <= True;
               inst_o       <= hit_data;
               inst_pc_o    <= pc_i;
            end
            if (start_miss) begin
               fpc <= pc_i;
               cnt <= 2'd0;
            end
            if (take_byte) begin
               cnt <= cnt + 2'd1;
               case (cnt)
                  2'd0:    asm_buf[7:0]   <= mem_byte_i;
                  2'd1:    asm_buf[15:8]  <= mem_byte_i;
                  2'd2:    asm_buf[23:16] <= mem_byte_i;
                  default: begin
                     inst_valid_o <= True;
                     inst_o       <= {mem_byte_i, asm_buf};
                     inst_pc_o    <= fpc;
                  end
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed and randomized checks of if_fetch against a
// transaction-level cache/memory model.
module tb_if_fetch;

   logic        clk = 1'b0;
   logic        rst, rdy, pc_valid_i, jump_i, mem_byte_valid_i, id_stall_i;
   logic [31:0] pc_i;
   logic [7:0]  mem_byte_i;
   logic        fetch_stall_o, mem_req_o, inst_valid_o;
   logic [31:0] mem_addr_o, inst_o, inst_pc_o;

   always #5 clk = ~clk;

   if_fetch dut (
      .clk              (clk),
      .rst              (rst),
      .rdy              (rdy),
      .pc_i             (pc_i),
      .pc_valid_i       (pc_valid_i),
      .fetch_stall_o    (fetch_stall_o),
      .jump_i           (jump_i),
      .mem_req_o        (mem_req_o),
      .mem_addr_o       (mem_addr_o),
      .mem_byte_i       (mem_byte_i),
      .mem_byte_valid_i (mem_byte_valid_i),
      .id_stall_i       (id_stall_i),
      .inst_valid_o     (inst_valid_o),
      .inst_o           (inst_o),
      .inst_pc_o        (inst_pc_o)
   );

   logic [7:0]  mem [0:1023];
   int          n_tests = 0;
   int          n_fail  = 0;
   bit          model_valid [32];
   int unsigned model_tag   [32];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      logic [9:0] i;
      i = a[9:0];
      return {mem[i + 10'd3], mem[i + 10'd2], mem[i + 10'd1], mem[i]};
   endfunction

   function automatic bit model_hit(input logic [31:0] pc);
      int unsigned idx;
      idx = (pc / 4) % 32;
      return model_valid[idx] && (model_tag[idx] == pc / 128);
   endfunction

   task automatic model_fill(input logic [31:0] pc);
      model_valid[(pc / 4) % 32] = 1'b1;
      model_tag[(pc / 4) % 32]   = pc / 128;
   endtask

   task automatic model_clear();
      for (int i = 0; i < 32; i++) model_valid[i] = 1'b0;
   endtask

   task automatic drive_byte(input bit give);
      if (give && mem_req_o) begin
         mem_byte_valid_i = 1'b1;
         mem_byte_i       = mem[mem_addr_o[9:0]];
      end else begin
         mem_byte_valid_i = 1'b0;
         mem_byte_i       = 8'($urandom);
      end
   endtask

   // One complete fetch: present pc, wait for the instruction, optionally hold
   // it with id_stall_i for 'hold' cycles, then let decode consume it.
   task automatic do_fetch(input logic [31:0] pc, input int gap_pct, input int hold, input string tag);
      bit exp_hit;
      bit saw_req = 1'b0;
      bit give;
      int gaps = 0;
      int bytes = 0;
      int cyc;
      exp_hit          = model_hit(pc);
      pc_i             = pc;
      pc_valid_i       = 1'b1;
      id_stall_i       = (hold > 0);
      mem_byte_valid_i = 1'b0;
      #1;
      check({tag, "_stall_in"}, {31'd0, fetch_stall_o}, {31'd0, !exp_hit});
      tick();
      pc_valid_i = 1'b0;
      cyc = 1;
      while (!inst_valid_o && cyc < 40) begin
         give = 1'b0;
         if (mem_req_o) begin
            saw_req = 1'b1;
            check({tag, "_stall_fill"}, {31'd0, fetch_stall_o}, 32'd1);
            give = ($urandom_range(99) >= gap_pct);
            if (give) begin
               check({tag, "_addr"}, mem_addr_o, pc + bytes);
               bytes++;
            end else
               gaps++;
         end
         drive_byte(give);
         tick();
         cyc++;
      end
      mem_byte_valid_i = 1'b0;
      check({tag, "_valid"}, {31'd0, inst_valid_o}, 32'd1);
      check({tag, "_latency"}, cyc, exp_hit ? 32'd1 : 32'(5 + gaps));
      check({tag, "_memreq"}, {31'd0, saw_req}, {31'd0, !exp_hit});
      check({tag, "_inst"}, inst_o, mem_word(pc));
      check({tag, "_pc"}, inst_pc_o, pc);
      model_fill(pc);
      for (int k = 0; k < hold; k++) begin
         check({tag, "_hold_stall"}, {31'd0, fetch_stall_o}, 32'd1);
         tick();
         check({tag, "_hold_valid"}, {31'd0, inst_valid_o}, 32'd1);
         check({tag, "_hold_inst"}, inst_o, mem_word(pc));
         check({tag, "_hold_pc"}, inst_pc_o, pc);
      end
      id_stall_i = 1'b0;
      tick();
      check({tag, "_consumed"}, {31'd0, inst_valid_o}, 32'd0);
      check({tag, "_idle_stall"}, {31'd0, fetch_stall_o}, 32'd0);
   endtask

   initial begin
      logic [31:0] held_addr;
      int          cyc;
      for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
      mem[0]     = 8'h13; mem[1]     = 8'h05; mem[2]     = 8'h10; mem[3]     = 8'h00;
      mem[10'h80] = 8'h6F; mem[10'h81] = 8'h00; mem[10'h82] = 8'h00; mem[10'h83] = 8'h00;
      model_clear();

      rst = 1'b1; rdy = 1'b1; pc_i = 32'd0; pc_valid_i = 1'b0; jump_i = 1'b0;
      mem_byte_i = 8'd0; mem_byte_valid_i = 1'b0; id_stall_i = 1'b0;
      tick(); tick();
      check("rst_valid", {31'd0, inst_valid_o}, 32'd0);
      check("rst_inst", inst_o, 32'd0);
      check("rst_pc", inst_pc_o, 32'd0);
      check("rst_req", {31'd0, mem_req_o}, 32'd0);
      check("rst_addr", mem_addr_o, 32'd0);
      rst = 1'b0;
      tick();
      check("rst_stall", {31'd0, fetch_stall_o}, 32'd0);

      // Cold miss, hit, aliasing
      do_fetch(32'h0, 0, 0, "cold");
      check("cold_word", inst_o, 32'h0010_0513);
      do_fetch(32'h0, 0, 0, "hit");
      check("hit_word", inst_o, 32'h0010_0513);
      do_fetch(32'h80, 0, 0, "alias");
      check("alias_word", inst_o, 32'h0000_006F);
      do_fetch(32'h0, 0, 0, "alias_back");

      // Flush after two bytes; a same-cycle pc_valid_i is ignored
      pc_i = 32'h104; pc_valid_i = 1'b1;
      tick();
      pc_valid_i = 1'b0;
      drive_byte(1'b1); tick();
      drive_byte(1'b1); tick();
      drive_byte(1'b1);
      jump_i = 1'b1; pc_i = 32'h0; pc_valid_i = 1'b1;
      tick();
      jump_i = 1'b0; pc_valid_i = 1'b0; mem_byte_valid_i = 1'b0;
      check("flush_req", {31'd0, mem_req_o}, 32'd0);
      check("flush_valid", {31'd0, inst_valid_o}, 32'd0);
      tick();
      check("flush_ignored_pc", {31'd0, inst_valid_o}, 32'd0);
      do_fetch(32'h104, 0, 0, "after_flush");

      // Decode backpressure over a hit
      do_fetch(32'h80, 0, 3, "bp");

      // rdy low for two cycles mid-fill
      pc_i = 32'h208; pc_valid_i = 1'b1;
      tick();
      pc_valid_i = 1'b0;
      drive_byte(1'b1); tick();
      drive_byte(1'b1); tick();
      held_addr = mem_addr_o;
      check("rdy_addr_pre", held_addr, 32'h20A);
      rdy = 1'b0;
      drive_byte(1'b1);
      for (int k = 0; k < 2; k++) begin
         tick();
         check("rdy_addr_frozen", mem_addr_o, held_addr);
         check("rdy_req_held", {31'd0, mem_req_o}, 32'd1);
         check("rdy_no_valid", {31'd0, inst_valid_o}, 32'd0);
      end
      rdy = 1'b1;
      cyc = 0;
      while (!inst_valid_o && cyc < 20) begin
         drive_byte(1'b1); tick(); cyc++;
      end
      mem_byte_valid_i = 1'b0;
      check("rdy_valid", {31'd0, inst_valid_o}, 32'd1);
      check("rdy_remaining", cyc, 32'd2);
      check("rdy_inst", inst_o, mem_word(32'h208));
      check("rdy_pc", inst_pc_o, 32'h208);
      model_fill(32'h208);
      tick();

      // Reset mid-fill
      pc_i = 32'h30C; pc_valid_i = 1'b1;
      tick();
      pc_valid_i = 1'b0;
      drive_byte(1'b1); tick();
      drive_byte(1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0; mem_byte_valid_i = 1'b0;
      check("mrst_valid", {31'd0, inst_valid_o}, 32'd0);
      check("mrst_inst", inst_o, 32'd0);
      check("mrst_pc", inst_pc_o, 32'd0);
      check("mrst_req", {31'd0, mem_req_o}, 32'd0);
      check("mrst_addr", mem_addr_o, 32'd0);
      check("mrst_stall", {31'd0, fetch_stall_o}, 32'd0);
      model_clear();
      do_fetch(32'h208, 0, 0, "mrst_empty");
      do_fetch(32'h30C, 0, 0, "mrst_nowrite");

      // Randomized fetch stream over a small, heavily aliased address set
      for (int n = 0; n < 120; n++) begin
         logic [31:0] rpc;
         rpc = (32'($urandom_range(0, 3)) << 7) | (32'($urandom_range(0, 3)) << 2);
         do_fetch(rpc, 30, int'($urandom_range(0, 2)), "rand");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
